// File: rtl/rmii_fcs_check.sv
// rtl/rmii_fcs_check.sv - CRC-32/length/address-sequence verdict over RMII receive buffer writes (optional FCS_STATS_EN verdict counters)
module rmii_fcs_check #(
    parameter int L       = 10,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic         rst,
    input  logic         clk,
    input  logic [L-1:0] offset,
    input  logic [L-1:0] addr,
    input  logic [7:0]   wdata,
    input  logic         we,
    input  logic         rdy,
    output logic         busy,
    output logic         done,
    output logic         good,
    output logic         crc_err,
    output logic         len_err,
    output logic         seq_err,
`ifdef FCS_STATS_EN
    input  logic         clr_stats,
    output logic [15:0]  cnt_good,
    output logic [15:0]  cnt_bad,
`endif
    output logic [L-1:0] frame_len
);

    localparam logic [31:0]  CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]  CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]  CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [L-1:0] ONE         = {{(L-1){1'b0}}, 1'b1};
    localparam logic [L-1:0] MIN_L       = MIN_LEN[L-1:0];
    localparam logic [L-1:0] MAX_L       = MAX_LEN[L-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [31:0]  crc, crc_nxt;
    logic [L-1:0] byte_cnt, byte_cnt_nxt;
    logic [L-1:0] exp_addr, exp_addr_nxt;
    logic         seq_flag, seq_flag_nxt;
    logic         verdict_frame;
    logic         verdict_empty;
    logic         start_wr;

    // Reflected CRC-32, LSB of the byte first, eight bit-steps unrolled
    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // A write at or past the preamble offset can open a new frame
    assign start_wr = we && (addr >= offset);

    assign busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accumulator updates and verdict requests
    always_comb begin
        state_nxt     = state;
        crc_nxt       = crc;
        byte_cnt_nxt  = byte_cnt;
        exp_addr_nxt  = exp_addr;
        seq_flag_nxt  = seq_flag;
        verdict_frame = 1'b0;
        verdict_empty = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_wr) begin
                    crc_nxt      = crc_fold(CRC_INIT, wdata);
                    byte_cnt_nxt = ONE;
                    exp_addr_nxt = addr + ONE;
                    seq_flag_nxt = 1'b0;
                    state_nxt    = rdy ? S_CHECK : S_DATA;
                end else if (rdy) begin
                    verdict_empty = 1'b1;
                end
            end
            S_DATA: begin
                if (we) begin
                    crc_nxt = crc_fold(crc, wdata);
                    if (byte_cnt != '1) begin
                        byte_cnt_nxt = byte_cnt + ONE;
                    end
                    if (addr != exp_addr) begin
                        seq_flag_nxt = 1'b1;
                    end
                    exp_addr_nxt = addr + ONE;
                end
                if (rdy) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                verdict_frame = 1'b1;
                // The next frame may already be starting; do not drop its first byte
                if (start_wr) begin
                    crc_nxt      = crc_fold(CRC_INIT, wdata);
                    byte_cnt_nxt = ONE;
                    exp_addr_nxt = addr + ONE;
                    seq_flag_nxt = 1'b0;
                    state_nxt    = S_DATA;
                end else begin
                    state_nxt    = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc      <= CRC_INIT;
            byte_cnt <= '0;
            exp_addr <= '0;
            seq_flag <= 1'b0;
        end else begin
            crc      <= crc_nxt;
            byte_cnt <= byte_cnt_nxt;
            exp_addr <= exp_addr_nxt;
            seq_flag <= seq_flag_nxt;
        end
    end

    // Verdict registers; flags hold between strobes, frame_len until the next verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            good      <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            seq_err   <= 1'b0;
            frame_len <= '0;
        end else begin
            done <= verdict_frame | verdict_empty;
            if (verdict_frame) begin
                frame_len <= byte_cnt;
                crc_err   <= (crc != CRC_RESIDUE);
                len_err   <= (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
                seq_err   <= seq_flag;
                good      <= (crc == CRC_RESIDUE) && (byte_cnt >= MIN_L) &&
                             (byte_cnt <= MAX_L) && !seq_flag;
            end else if (verdict_empty) begin
                frame_len <= '0;
                crc_err   <= 1'b1;
                len_err   <= 1'b1;
                seq_err   <= 1'b0;
                good      <= 1'b0;
            end
        end
    end

`ifdef FCS_STATS_EN
    // Saturating good/bad verdict counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_good <= 16'h0;
            cnt_bad  <= 16'h0;
        end else if (clr_stats) begin
            cnt_good <= 16'h0;
            cnt_bad  <= 16'h0;
        end else if (done) begin
            if (good) begin
                if (cnt_good != 16'hFFFF) cnt_good <= cnt_good + 16'h1;
            end else begin
                if (cnt_bad != 16'hFFFF) cnt_bad <= cnt_bad + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rmii_fcs_check.sv
// tb/tb_rmii_fcs_check.sv - randomized self-checking bench for rmii_fcs_check against a frame-level model
module tb_rmii_fcs_check;

    localparam int L = 11;

    logic         rst, clk;
    logic [L-1:0] offset, addr, frame_len;
    logic [7:0]   wdata;
    logic         we, rdy, busy, done, good, crc_err, len_err, seq_err;
`ifdef FCS_STATS_EN
    logic         clr_stats;
    logic [15:0]  cnt_good, cnt_bad;
`endif

    rmii_fcs_check #(.L(L), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .rst(rst), .clk(clk), .offset(offset), .addr(addr), .wdata(wdata),
        .we(we), .rdy(rdy), .busy(busy), .done(done), .good(good),
        .crc_err(crc_err), .len_err(len_err), .seq_err(seq_err),
`ifdef FCS_STATS_EN
        .clr_stats(clr_stats), .cnt_good(cnt_good), .cnt_bad(cnt_bad),
`endif
        .frame_len(frame_len)
    );

    typedef struct {
        int edge_n;
        int len;
        bit crc_e;
        bit len_e;
        bit seq_e;
        bit gd;
    } exp_t;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc_cnt = 0;
    bit         checking = 0;
    bit         in_frame = 0;
    logic [7:0] frm[$];
    logic [7:0] mb[$];
    int         ma[$];
    exp_t       expq[$];

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc_cnt);
    endtask

    // Standard Ethernet CRC-32 (reflected, init all ones, final inversion)
    function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Frame verdict from the written byte/address list
    task automatic push_verdict(input int base_edge);
        exp_t        e;
        int          n;
        logic [31:0] fcs;
        bit          fcs_ok;
        if (!in_frame) begin
            e = '{base_edge, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            n = mb.size();
            e.edge_n = base_edge + 1;
            e.len    = (n > 2047) ? 2047 : n;
            e.seq_e  = 0;
            for (int i = 1; i < n; i++)
                if (ma[i] != ((ma[i-1] + 1) % 2048)) e.seq_e = 1;
            fcs_ok = 0;
            if (n >= 4) begin
                fcs = crc32(mb, n - 4);
                fcs_ok = (fcs == {mb[n-1], mb[n-2], mb[n-3], mb[n-4]});
            end
            e.crc_e = !fcs_ok;
            e.len_e = (e.len < 64) || (e.len > 1518);
            e.gd    = !(e.crc_e || e.len_e || e.seq_e);
        end
        in_frame = 0;
        expq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d, input bit r);
        addr = a[L-1:0]; wdata = d; we = 1; rdy = r;
        if (!in_frame && a >= 8) begin
            in_frame = 1; mb.delete(); ma.delete();
        end
        if (in_frame) begin
            mb.push_back(d); ma.push_back(a);
        end
        if (r) push_verdict(cyc_cnt + 1);
        cyc();
        we = 0; rdy = 0;
    endtask

    task automatic pulse_rdy();
        rdy = 1;
        push_verdict(cyc_cnt + 1);
        cyc();
        rdy = 0;
    endtask

    task automatic drain();
        repeat (4) cyc();
    endtask

    task automatic build(input int n, input bit zero);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(zero ? 8'h00 : 8'($urandom));
        c = crc32(frm, n - 4);
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    task automatic send(input bit pre, input int skip_a, input int flip_a,
                        input bit rdy_last, input int gap, input bit do_rdy);
        logic [7:0] d;
        bit         last;
        if (pre) for (int i = 0; i < 8; i++) wr(i, (i == 7) ? 8'hD5 : 8'h55, 0);
        for (int i = 0; i < frm.size(); i++) begin
            if (8 + i == skip_a) continue;
            d = frm[i];
            if (8 + i == flip_a) d = d ^ 8'h01;
            last = (i == frm.size() - 1);
            wr(8 + i, d, rdy_last && last && do_rdy);
            if (!last && gap > 0) repeat ($urandom_range(0, gap)) cyc();
        end
        if (do_rdy && !rdy_last) pulse_rdy();
    endtask

    // Cycle-by-cycle comparison of the verdict strobe and fields against the model
    always @(negedge clk) begin
        bit exp_now;
        if (!rst && checking) begin
            exp_now = (expq.size() > 0) && (expq[0].edge_n == cyc_cnt);
            chk("done", done, exp_now);
            if (exp_now) begin
                if (done) begin
                    chk("frame_len", frame_len, expq[0].len);
                    chk("good", good, expq[0].gd);
                    chk("crc_err", crc_err, expq[0].crc_e);
                    chk("len_err", len_err, expq[0].len_e);
                    chk("seq_err", seq_err, expq[0].seq_e);
                end
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] pin[$];
        int         n, flip, skip;
        rst = 1; we = 0; rdy = 0; addr = '0; wdata = '0; offset = 11'd8;
`ifdef FCS_STATS_EN
        clr_stats = 0;
`endif
        repeat (3) cyc();
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_good", good, 0);
        chk("rst_flags", {crc_err, len_err, seq_err}, 0);
        chk("rst_frame_len", frame_len, 0);
        rst = 0;
        checking = 1;
        cyc();

        pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_model_pin", crc32(pin, 9), 32'hCBF43926);

        build(64, 1);
        send(1, -1, -1, 0, 0, 1); drain();
        chk("preamble_len", frame_len, 64);
        chk("preamble_good_q", good, 1);

        send(1, -1, 20, 0, 0, 1); drain();
        chk("corrupt_len", frame_len, 64);
        chk("corrupt_crc_err", crc_err, 1);

        build(63, 0);   send(1, -1, -1, 0, 0, 1); drain();
        chk("short_len_err", len_err, 1);
        build(1518, 0); send(1, -1, -1, 0, 0, 1); drain();
        chk("max_len", frame_len, 1518);
        chk("max_good", good, 1);
        build(1519, 0); send(1, -1, -1, 0, 0, 1); drain();
        chk("over_len", frame_len, 1519);

        build(64, 0); send(1, 30, -1, 0, 0, 1); drain();
        chk("seq_len", frame_len, 63);
        chk("seq_err_q", seq_err, 1);

        build(64, 0); send(1, -1, -1, 0, 0, 1);
        build(70, 0); send(0, -1, -1, 0, 0, 1); drain();
        chk("b2b_len", frame_len, 70);

        build(64, 0); send(1, -1, -1, 1, 0, 1); drain();

        build(64, 0);
        for (int i = 0; i < 8; i++) wr(i, 8'h55, 0);
        for (int i = 0; i < 10; i++) wr(8 + i, frm[i], 0);
        chk("mid_busy", busy, 1);
        rst = 1; in_frame = 0;
        #2;
        chk("rst_busy_async", busy, 0);
        chk("rst_done_async", done, 0);
        cyc();
        rst = 0;
        cyc();
        send(1, -1, -1, 0, 0, 1); drain();

        pulse_rdy(); drain();
        chk("empty_len", frame_len, 0);
        for (int i = 0; i < 8; i++) wr(i, 8'h55, 0);
        pulse_rdy(); drain();

        for (int f = 0; f < 16; f++) begin
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(30, 63) : $urandom_range(64, 140);
            build(n, 0);
            flip = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 8 + n - 1) : -1;
            skip = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 8 + n - 2) : -1;
            send(1'($urandom_range(0, 1)), skip, flip, 1'($urandom_range(0, 1)), 2, 1);
            drain();
        end

`ifdef FCS_STATS_EN
        clr_stats = 1; cyc(); clr_stats = 0;
        for (int f = 0; f < 5; f++) begin
            build(64, 0);
            send(1, -1, (f < 3) ? -1 : 12, 0, 0, 1); drain();
        end
        chk("cnt_good", cnt_good, 3);
        chk("cnt_bad", cnt_bad, 2);
        build(64, 0); send(1, -1, -1, 0, 0, 1);
        cyc();
        clr_stats = 1; cyc(); clr_stats = 0;
        chk("clr_good", cnt_good, 0);
        chk("clr_bad", cnt_bad, 0);
        drain();
`endif

        drain();
        chk("verdicts_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
